// File: rtl/ulpi_defs.sv
// Shared constants for the ULPI link: command codes, register addresses,
// RX CMD event codes and the TX/register FSM encoding.
`timescale 1ns/1ps
package ulpi_defs;

   localparam logic [1:0] CMD_TX     = 2'b01;
   localparam logic [1:0] CMD_REG_WR = 2'b10;
   localparam logic [1:0] CMD_REG_RD = 2'b11;

   localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
   localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;

   typedef enum logic [1:0] {
      RXEV_IDLE     = 2'b00,
      RXEV_ACTIVE   = 2'b01,
      RXEV_HOSTDISC = 2'b10,
      RXEV_ERROR    = 2'b11
   } rx_event_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_TX_CMD   = 3'd1,
      ST_TX_DATA  = 3'd2,
      ST_TX_STP   = 3'd3,
      ST_REG_ADDR = 3'd4,
      ST_REG_DATA = 3'd5,
      ST_REG_STP  = 3'd6
   } tx_state_e;

   // SuspendM is held at 1 so the PHY never enters low-power mode on its own.
   function automatic logic [7:0] func_ctrl_val(input logic [1:0] op_mode,
                                                input logic       term,
                                                input logic [1:0] xcvr);
      return {1'b0, 1'b1, 1'b0, op_mode, term, xcvr};
   endfunction

   function automatic logic [7:0] otg_ctrl_val(input logic dm_pd,
                                               input logic dp_pd);
      return {5'b00000, dm_pd, dp_pd, 1'b0};
   endfunction

endpackage

// File: rtl/ulpi_link_utmi.sv
// ULPI link-side wrapper presenting a UTMI interface: RX CMD / RX data decode,
// TX packet transmission and shadowed PHY register writes.
`timescale 1ns/1ps
module ulpi_link_utmi
   import ulpi_defs::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] ulpi_data_i,
   output logic [7:0] ulpi_data_o,
   input  logic       ulpi_dir_i,
   input  logic       ulpi_nxt_i,
   output logic       ulpi_stp_o,
   input  logic [7:0] utmi_data_out_i,
   input  logic       utmi_txvalid_i,
   output logic       utmi_txready_o,
   output logic [7:0] utmi_data_in_o,
   output logic       utmi_rxvalid_o,
   output logic       utmi_rxactive_o,
   output logic       utmi_rxerror_o,
   output logic [1:0] utmi_linestate_o,
   input  logic [1:0] utmi_op_mode_i,
   input  logic [1:0] utmi_xcvrselect_i,
   input  logic       utmi_termselect_i,
   input  logic       utmi_dppulldown_i,
   input  logic       utmi_dmpulldown_i
);

   tx_state_e  state_q, state_d;
   logic       dir_q;
   logic       wr_otg_q, wr_otg_d;
   logic [7:0] wr_val_q, wr_val_d;
   logic [7:0] func_copy_q, otg_copy_q;
   logic       copy_load;

   logic [7:0] data_in_q;
   logic       rxvalid_q, rxactive_q, rxerror_q;
   logic [1:0] linestate_q;

   logic       turnaround, dir_rise, dir_fall;
   logic [7:0] func_live, otg_live;
   logic       func_pend, otg_pend;

   assign turnaround = dir_q ^ ulpi_dir_i;
   assign dir_rise   = ulpi_dir_i & ~dir_q;
   assign dir_fall   = ~ulpi_dir_i & dir_q;

   assign func_live = func_ctrl_val(utmi_op_mode_i, utmi_termselect_i, utmi_xcvrselect_i);
   assign otg_live  = otg_ctrl_val(utmi_dmpulldown_i, utmi_dppulldown_i);
   assign func_pend = (func_live != func_copy_q);
   assign otg_pend  = (otg_live != otg_copy_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         dir_q       <= 1'b0;
         wr_otg_q    <= 1'b0;
         wr_val_q    <= '0;
         func_copy_q <= '1;
         otg_copy_q  <= '1;
      end else begin
         state_q  <= state_d;
         dir_q    <= ulpi_dir_i;
         wr_otg_q <= wr_otg_d;
         wr_val_q <= wr_val_d;
         if (copy_load) begin
            if (wr_otg_q) otg_copy_q  <= wr_val_q;
            else          func_copy_q <= wr_val_q;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      wr_otg_d       = wr_otg_q;
      wr_val_d       = wr_val_q;
      copy_load      = 1'b0;
      ulpi_data_o    = '0;
      ulpi_stp_o     = 1'b0;
      utmi_txready_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!ulpi_dir_i && !turnaround) begin
               if (func_pend) begin
                  state_d  = ST_REG_ADDR;
                  wr_otg_d = 1'b0;
                  wr_val_d = func_live;
               end else if (otg_pend) begin
                  state_d  = ST_REG_ADDR;
                  wr_otg_d = 1'b1;
                  wr_val_d = otg_live;
               end else if (utmi_txvalid_i) begin
                  state_d = ST_TX_CMD;
               end
            end
         end
         ST_TX_CMD: begin
            ulpi_data_o = {CMD_TX, 2'b00, utmi_data_out_i[3:0]};
            if (ulpi_dir_i) begin
               state_d = ST_IDLE;
            end else begin
               utmi_txready_o = ulpi_nxt_i;
               if (ulpi_nxt_i) state_d = ST_TX_DATA;
            end
         end
         ST_TX_DATA: begin
            ulpi_data_o = utmi_data_out_i;
            if (ulpi_dir_i) begin
               state_d = ST_IDLE;
            end else if (!utmi_txvalid_i) begin
               state_d = ST_TX_STP;
            end else begin
               utmi_txready_o = ulpi_nxt_i;
            end
         end
         ST_TX_STP, ST_REG_STP: begin
            ulpi_stp_o = 1'b1;
            state_d    = ST_IDLE;
         end
         ST_REG_ADDR: begin
            ulpi_data_o = {CMD_REG_WR, wr_otg_q ? ADDR_OTG_CTRL : ADDR_FUNC_CTRL};
            if (ulpi_dir_i)      state_d = ST_IDLE;
            else if (ulpi_nxt_i) state_d = ST_REG_DATA;
         end
         ST_REG_DATA: begin
            ulpi_data_o = wr_val_q;
            if (ulpi_dir_i) begin
               state_d = ST_IDLE;
            end else if (ulpi_nxt_i) begin
               state_d   = ST_REG_STP;
               copy_load = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // The PHY owns the bus while dir is high, so never drive a value then.
      if (ulpi_dir_i) ulpi_data_o = '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_in_q   <= '0;
         rxvalid_q   <= 1'b0;
         rxactive_q  <= 1'b0;
         rxerror_q   <= 1'b0;
         linestate_q <= '0;
      end else begin
         rxvalid_q <= 1'b0;
         if (dir_rise) begin
            if (ulpi_nxt_i) rxactive_q <= 1'b1;
         end else if (dir_fall) begin
            rxactive_q <= 1'b0;
            rxerror_q  <= 1'b0;
         end else if (ulpi_dir_i) begin
            if (ulpi_nxt_i) begin
               data_in_q <= ulpi_data_i;
               rxvalid_q <= 1'b1;
            end else begin
               linestate_q <= ulpi_data_i[1:0];
               case (rx_event_e'(ulpi_data_i[5:4]))
                  RXEV_ACTIVE: begin
                     rxactive_q <= 1'b1;
                     rxerror_q  <= 1'b0;
                  end
                  RXEV_ERROR: begin
                     rxactive_q <= 1'b1;
                     rxerror_q  <= 1'b1;
                  end
                  default: begin
                     rxactive_q <= 1'b0;
                     rxerror_q  <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign utmi_data_in_o   = data_in_q;
   assign utmi_rxvalid_o   = rxvalid_q;
   assign utmi_rxactive_o  = rxactive_q;
   assign utmi_rxerror_o   = rxerror_q;
   assign utmi_linestate_o = linestate_q;

endmodule

// File: tb/tb_ulpi_link_utmi.sv
// Self-checking bench for ulpi_link_utmi: directed register/TX/RX scenarios
// plus randomized traffic checked against expectations derived from the bus rules.
`timescale 1ns/1ps
module tb_ulpi_link_utmi;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ulpi_data_i, ulpi_data_o;
   logic       ulpi_dir_i, ulpi_nxt_i, ulpi_stp_o;
   logic [7:0] utmi_data_out_i;
   logic       utmi_txvalid_i, utmi_txready_o;
   logic [7:0] utmi_data_in_o;
   logic       utmi_rxvalid_o, utmi_rxactive_o, utmi_rxerror_o;
   logic [1:0] utmi_linestate_o;
   logic [1:0] utmi_op_mode_i, utmi_xcvrselect_i;
   logic       utmi_termselect_i, utmi_dppulldown_i, utmi_dmpulldown_i;

   int tests = 0;
   int fails = 0;

   int unsigned func_last, otg_last;
   logic [7:0]  tx_pkt [0:7];
   int          tx_len;

   always #5 clk = ~clk;

   ulpi_link_utmi dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .ulpi_data_i       (ulpi_data_i),
      .ulpi_data_o       (ulpi_data_o),
      .ulpi_dir_i        (ulpi_dir_i),
      .ulpi_nxt_i        (ulpi_nxt_i),
      .ulpi_stp_o        (ulpi_stp_o),
      .utmi_data_out_i   (utmi_data_out_i),
      .utmi_txvalid_i    (utmi_txvalid_i),
      .utmi_txready_o    (utmi_txready_o),
      .utmi_data_in_o    (utmi_data_in_o),
      .utmi_rxvalid_o    (utmi_rxvalid_o),
      .utmi_rxactive_o   (utmi_rxactive_o),
      .utmi_rxerror_o    (utmi_rxerror_o),
      .utmi_linestate_o  (utmi_linestate_o),
      .utmi_op_mode_i    (utmi_op_mode_i),
      .utmi_xcvrselect_i (utmi_xcvrselect_i),
      .utmi_termselect_i (utmi_termselect_i),
      .utmi_dppulldown_i (utmi_dppulldown_i),
      .utmi_dmpulldown_i (utmi_dmpulldown_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample point: half a cycle away from the active edge; inputs change here too.
   task automatic nb();
      @(negedge clk);
      #1;
   endtask

   // Register values built from the documented bit positions.
   function automatic int unsigned func_model(int unsigned op, int unsigned term, int unsigned xcvr);
      return 64 + op * 8 + term * 4 + xcvr;
   endfunction

   function automatic int unsigned otg_model(int unsigned dm, int unsigned dp);
      return dm * 4 + dp * 2;
   endfunction

   task automatic expect_write(input int unsigned addr, input int unsigned val);
      bit found = 0;
      for (int i = 0; i < 20; i++) begin
         nb();
         if (ulpi_data_o[7:6] == 2'b10) begin
            found = 1;
            break;
         end
      end
      chk("reg_start", found, 1);
      if (found) begin
         chk("reg_addr", ulpi_data_o, 128 + addr);
         chk("reg_addr_txready", utmi_txready_o, 0);
         nb();
         chk("reg_data", ulpi_data_o, val);
         chk("reg_data_stp", ulpi_stp_o, 0);
         nb();
         chk("reg_stp", ulpi_stp_o, 1);
         chk("reg_stp_data", ulpi_data_o, 0);
      end
   endtask

   // Assumes txvalid is already asserted with tx_pkt[0] on utmi_data_out_i.
   task automatic tx_collect();
      logic [7:0] obs [$];
      int         idx = 0;
      bit         stp_seen = 0;
      logic [7:0] stp_data = '1;
      for (int c = 0; c < 30; c++) begin
         nb();
         if (ulpi_stp_o) begin
            stp_seen = 1;
            stp_data = ulpi_data_o;
            break;
         end
         if (utmi_txready_o) begin
            obs.push_back(ulpi_data_o);
            idx++;
            if (idx < tx_len) utmi_data_out_i = tx_pkt[idx];
            else              utmi_txvalid_i  = 1'b0;
         end
      end
      utmi_txvalid_i = 1'b0;
      chk("tx_stp_seen", stp_seen, 1);
      chk("tx_stp_data", stp_data, 0);
      chk("tx_ready_count", obs.size(), tx_len);
      for (int i = 0; i < tx_len && i < obs.size(); i++) begin
         if (i == 0) chk("tx_cmd", obs[0], 64 + (tx_pkt[0] % 16));
         else        chk("tx_byte", obs[i], tx_pkt[i]);
      end
   endtask

   task automatic send_packet();
      utmi_data_out_i = tx_pkt[0];
      utmi_txvalid_i  = 1'b1;
      tx_collect();
   endtask

   initial begin
      int unsigned op, xcvr, term, dm, dp, fnew, onew, n, ls, b;
      logic [7:0] rxb [0:7];

      rst = 1'b1;
      ulpi_data_i = '0; ulpi_dir_i = 1'b0; ulpi_nxt_i = 1'b1;
      utmi_data_out_i = '0; utmi_txvalid_i = 1'b0;
      op = 0; xcvr = 1; term = 0; dm = 0; dp = 0;
      utmi_op_mode_i = 2'(op); utmi_xcvrselect_i = 2'(xcvr); utmi_termselect_i = 1'(term);
      utmi_dppulldown_i = 1'(dp); utmi_dmpulldown_i = 1'(dm);
      repeat (3) nb();

      chk("rst_data_o", ulpi_data_o, 0);
      chk("rst_stp", ulpi_stp_o, 0);
      chk("rst_txready", utmi_txready_o, 0);
      chk("rst_rxvalid", utmi_rxvalid_o, 0);
      chk("rst_rxactive", utmi_rxactive_o, 0);
      chk("rst_rxerror", utmi_rxerror_o, 0);
      chk("rst_linestate", utmi_linestate_o, 0);
      chk("rst_data_in", utmi_data_in_o, 0);
      rst = 1'b0;

      // Both shadows differ from the reset copies, so both writes follow reset.
      expect_write(4, func_model(op, term, xcvr));
      expect_write(10, otg_model(dm, dp));
      func_last = func_model(op, term, xcvr);
      otg_last  = otg_model(dm, dp);
      nb();
      chk("idle_stp", ulpi_stp_o, 0);
      chk("idle_data", ulpi_data_o, 0);

      for (int it = 0; it < 4; it++) begin
         op = $urandom_range(0, 3); xcvr = $urandom_range(0, 3); term = $urandom_range(0, 1);
         dm = $urandom_range(0, 1); dp = $urandom_range(0, 1);
         utmi_op_mode_i = 2'(op); utmi_xcvrselect_i = 2'(xcvr); utmi_termselect_i = 1'(term);
         utmi_dppulldown_i = 1'(dp); utmi_dmpulldown_i = 1'(dm);
         fnew = func_model(op, term, xcvr);
         onew = otg_model(dm, dp);
         if (fnew != func_last) expect_write(4, fnew);
         if (onew != otg_last)  expect_write(10, onew);
         func_last = fnew;
         otg_last  = onew;
         repeat (2) nb();
         chk("rand_idle_stp", ulpi_stp_o, 0);
         chk("rand_idle_data", ulpi_data_o, 0);
      end

      tx_pkt[0] = 8'hC3; tx_pkt[1] = 8'h00; tx_pkt[2] = 8'h10; tx_len = 3;
      send_packet();

      for (int it = 0; it < 4; it++) begin
         tx_len = $urandom_range(1, 6);
         for (int i = 0; i < tx_len; i++) tx_pkt[i] = 8'($urandom);
         repeat (2) nb();
         send_packet();
      end

      // Register write must win over a simultaneous TX request.
      nb();
      op = (op + 1) % 4;
      utmi_op_mode_i = 2'(op);
      tx_pkt[0] = 8'h69; tx_pkt[1] = 8'h5A; tx_len = 2;
      utmi_data_out_i = tx_pkt[0];
      utmi_txvalid_i  = 1'b1;
      func_last = func_model(op, term, xcvr);
      expect_write(4, func_last);
      tx_collect();

      // RX packet: turnaround with nxt, two data bytes, RX CMD, dir drops.
      nb();
      ulpi_dir_i = 1'b1; ulpi_nxt_i = 1'b1; ulpi_data_i = 8'hFF;
      #1 chk("rx_bus_released", ulpi_data_o, 0);
      nb();
      chk("rx_active_rise", utmi_rxactive_o, 1);
      chk("rx_turn_novalid", utmi_rxvalid_o, 0);
      ulpi_data_i = 8'h2D;
      nb();
      chk("rx_valid0", utmi_rxvalid_o, 1);
      chk("rx_data0", utmi_data_in_o, 8'h2D);
      ulpi_data_i = 8'h01;
      nb();
      chk("rx_valid1", utmi_rxvalid_o, 1);
      chk("rx_data1", utmi_data_in_o, 8'h01);
      ulpi_nxt_i = 1'b0; ulpi_data_i = 8'h00;
      nb();
      chk("rx_cmd_novalid", utmi_rxvalid_o, 0);
      ulpi_dir_i = 1'b0; ulpi_nxt_i = 1'b1;
      nb();
      chk("rx_active_fall", utmi_rxactive_o, 0);

      // Randomized RX packets.
      for (int it = 0; it < 3; it++) begin
         n  = $urandom_range(1, 5);
         ls = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) rxb[i] = 8'($urandom);
         nb();
         ulpi_dir_i = 1'b1; ulpi_nxt_i = 1'b1; ulpi_data_i = 8'($urandom);
         nb();
         chk("rrx_active", utmi_rxactive_o, 1);
         for (int i = 0; i < n; i++) begin
            ulpi_data_i = rxb[i];
            nb();
            chk("rrx_valid", utmi_rxvalid_o, 1);
            chk("rrx_data", utmi_data_in_o, rxb[i]);
            chk("rrx_bus", ulpi_data_o, 0);
         end
         ulpi_nxt_i = 1'b0; ulpi_data_i = 8'(16 + ls);
         nb();
         chk("rrx_cmd_novalid", utmi_rxvalid_o, 0);
         chk("rrx_cmd_ls", utmi_linestate_o, ls);
         chk("rrx_cmd_active", utmi_rxactive_o, 1);
         ulpi_dir_i = 1'b0; ulpi_nxt_i = 1'b1;
         nb();
         chk("rrx_end_active", utmi_rxactive_o, 0);
      end

      // RX CMD decoding without an active packet.
      nb();
      ulpi_dir_i = 1'b1; ulpi_nxt_i = 1'b0; ulpi_data_i = 8'h00;
      nb();
      chk("rxcmd_turn_inactive", utmi_rxactive_o, 0);
      ulpi_data_i = 8'h03;
      nb();
      chk("rxcmd03_ls", utmi_linestate_o, 3);
      chk("rxcmd03_active", utmi_rxactive_o, 0);
      chk("rxcmd03_error", utmi_rxerror_o, 0);
      ulpi_data_i = 8'h31;
      nb();
      chk("rxcmd31_ls", utmi_linestate_o, 1);
      chk("rxcmd31_active", utmi_rxactive_o, 1);
      chk("rxcmd31_error", utmi_rxerror_o, 1);
      for (int it = 0; it < 6; it++) begin
         b = $urandom_range(0, 255);
         ulpi_data_i = 8'(b);
         nb();
         chk("rrxcmd_ls", utmi_linestate_o, b % 4);
         chk("rrxcmd_active", utmi_rxactive_o, (b / 16) % 2);
         chk("rrxcmd_error", utmi_rxerror_o, ((b / 16) % 4) == 3);
      end
      ulpi_data_i = 8'h31;
      nb();
      ulpi_dir_i = 1'b0; ulpi_nxt_i = 1'b1;
      nb();
      chk("rxcmd_fall_active", utmi_rxactive_o, 0);
      chk("rxcmd_fall_error", utmi_rxerror_o, 0);

      // PHY grabs the bus during REG_DATA: the write must be reissued unchanged.
      nb();
      dm = 1 - dm;
      utmi_dmpulldown_i = 1'(dm);
      otg_last = otg_model(dm, dp);
      begin
         bit found = 0;
         for (int i = 0; i < 20; i++) begin
            nb();
            if (ulpi_data_o[7:6] == 2'b10) begin
               found = 1;
               break;
            end
         end
         chk("abort_start", found, 1);
         chk("abort_addr", ulpi_data_o, 128 + 10);
      end
      nb();
      chk("abort_data", ulpi_data_o, otg_last);
      ulpi_dir_i = 1'b1; ulpi_nxt_i = 1'b0; ulpi_data_i = 8'h00;
      #1 chk("abort_bus_released", ulpi_data_o, 0);
      repeat (3) begin
         nb();
         chk("abort_no_stp", ulpi_stp_o, 0);
      end
      ulpi_dir_i = 1'b0; ulpi_nxt_i = 1'b1;
      expect_write(10, otg_last);
      repeat (3) nb();
      chk("final_idle_data", ulpi_data_o, 0);
      chk("final_idle_stp", ulpi_stp_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
